// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Walks a script of 4-bit opcodes held in a synchronous command ROM and hands
// each one to the LCD image controller under its busy handshake. Every run
// ends with a Write (opcode 0), either from the ROM or issued implicitly after
// the last entry, and then waits for the controller's done.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse, begins a run (only honoured when idle)
//   rom_q        ROM data, valid the cycle after rom_rd
//   rom_rd       ROM read enable
//   rom_a        ROM address
//   cmd          opcode to the controller
//   cmd_valid    one-cycle opcode strobe to the controller
//   lcd_busy     controller busy
//   lcd_done     controller done
//   seq_busy     run in progress
//   seq_done     run finished, held until the next start
//   err          sticky, an illegal opcode (12..15) was seen this run
//   issued_cnt   commands issued this run (saturating), final Write included
module lcd_cmd_sequencer #(
    parameter int AW          = 5,
    parameter int CMD_DEPTH   = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    rom_q,
    output logic          rom_rd,
    output logic [AW-1:0] rom_a,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          lcd_busy,
    input  logic          lcd_done,
    output logic          seq_busy,
    output logic          seq_done,
    output logic          err,
    output logic [AW:0]   issued_cnt
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(CMD_DEPTH - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READY,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_ACK,
        S_RELEASE,
        S_NEXT,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    rom_a_q, rom_a_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             seq_busy_q, seq_busy_d;
    logic             seq_done_q, seq_done_d;
    logic             err_q, err_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rom_a_q    <= '0;
            cmd_q      <= '0;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            ack_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rom_a_q    <= rom_a_d;
            cmd_q      <= cmd_d;
            seq_busy_q <= seq_busy_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_a_d    = rom_a_q;
        cmd_d      = cmd_q;
        seq_busy_d = seq_busy_q;
        seq_done_d = seq_done_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        ack_cnt_d  = ack_cnt_q;
        rom_rd     = 1'b0;
        cmd_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    seq_done_d = 1'b0;
                    seq_busy_d = 1'b1;
                    rom_a_d    = '0;
                    state_d    = S_READY;
                end
            end
            // Controller may still be loading its initial image.
            S_READY: begin
                if (!lcd_busy) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_rd  = 1'b1;
                state_d = S_LATCH;
            end
            // Illegal opcodes are dropped without touching cmd, so cmd only
            // ever carries opcodes the controller may legitimately see.
            S_LATCH: begin
                if (rom_q[3] && rom_q[2]) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    cmd_d   = rom_q;
                    state_d = S_ISSUE;
                end
            end
            // Strobe is only raised while the controller is free; leaving the
            // state in the same cycle guarantees a single-cycle pulse.
            S_ISSUE: begin
                if (!lcd_busy) begin
                    cmd_valid = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    ack_cnt_d = '0;
                    state_d   = (cmd_q == 4'd0) ? S_WAIT_DONE : S_ACK;
                end
            end
            // A controller that never raises busy is treated as having
            // accepted the command once the timeout runs out.
            S_ACK: begin
                if (lcd_busy) begin
                    state_d = S_RELEASE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lcd_busy) state_d = S_NEXT;
            end
            // Running off the end of the ROM without a Write issues one.
            S_NEXT: begin
                if (rom_a_q == LAST_ADDR) begin
                    cmd_d   = 4'd0;
                    state_d = S_ISSUE;
                end else begin
                    rom_a_d = rom_a_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_DONE: begin
                if (lcd_done) begin
                    seq_busy_d = 1'b0;
                    seq_done_d = 1'b1;
                    state_d    = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_a      = rom_a_q;
    assign cmd        = cmd_q;
    assign seq_busy   = seq_busy_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;
    assign issued_cnt = cnt_q;

endmodule
